keyboard_port_controller: RTL
=============================

Name: keyboard_port_controller

Overview:
Sequences the hex keyboard encoder feeding input port 1. Debounces raw keystrokes, assembles two hex nibbles (high first) into one byte, and presents it on the port-1 data lines. Raises READY (port 2 bit 0) and holds the byte until the CPU acknowledges the read.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable CLK cycles required to accept a press or a release (legal range 1..255).
CNT_W, 8, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
CLK  input  1  clock; all logic on posedge.
CLR  input  1  synchronous reset, active-high.
key_code  input  4  hex value from the encoder; valid while key_strobe is high.
key_strobe  input  1  raw, bouncy "key down" from the encoder.
acknowedge  input  1  CPU read strobe for port 1; one or more cycles high.
port_data  output  8  assembled byte to the input-port-1 Keyboard lines.
ready  output  1  byte valid; drives port 2 bit 0.
nibble_pending  output  1  high nibble captured, low nibble awaited.
overrun  output  1  sticky keystroke-lost flag (see Optional Feature).

Behaviour:
- Reset (CLR=1 at posedge): state=IDLE, counter=0, port_data=8'h00, ready=0, nibble_pending=0, overrun=0. Reset wins over every other event, including mid-debounce and while ready.
- FSM states: IDLE, PRESS_DB, RELEASE_WAIT, RELEASE_DB.
- IDLE:
  - key_strobe=1 -> PRESS_DB, counter=1.
- PRESS_DB:
  - key_strobe=0 -> IDLE, counter=0 (bounce rejected).
  - key_strobe=1 and counter==DEBOUNCE_CYCLES-1 -> key accepted: sample key_code this cycle, go to RELEASE_WAIT.
  - Otherwise counter++.
  - With DEBOUNCE_CYCLES=1, acceptance occurs on the first cycle strobe is seen high.
- Acceptance, not ready:
  - nibble_pending=0: hold[7:4]=key_code, nibble_pending<=1.
  - nibble_pending=1: port_data<={hold[7:4], key_code}, ready<=1, nibble_pending<=0. port_data and ready update on the same edge.
- Acceptance while ready=1: keystroke discarded; port_data, nibble_pending and ready unchanged.
- RELEASE_WAIT:
  - key_strobe=0 -> RELEASE_DB, counter=1.
- RELEASE_DB:
  - key_strobe=1 -> RELEASE_WAIT (bounce).
  - key_strobe=0 and counter==DEBOUNCE_CYCLES-1 -> IDLE.
  - Otherwise counter++.
  - A held key yields exactly one acceptance.
- Handshake:
  - ready clears on the posedge after acknowedge is sampled high while ready=1.
  - port_data is held (not cleared) after acknowledge.
  - acknowedge while ready=0 is ignored.
  - Acceptance and acknowledge on the same edge: the acknowledge clears ready first, then the acceptance is processed as "not ready". Only the high nibble can be captured that cycle, since nibble_pending=0 whenever ready=1.
- Counter saturates and never wraps; values outside the debounce states are don't-care but reset to 0 on entry to IDLE.
- Latency: low-nibble stable-high strobe to ready=1 is exactly DEBOUNCE_CYCLES cycles after the first high sample.

Optional Feature:
KBD_OVERRUN_EN
- Defined: an accepted keystroke discarded because ready=1 sets overrun<=1.
  - overrun is sticky until CLR.
  - A same-edge acknowledge prevents overrun.
- Undefined: overrun is tied to 0; discard behaviour is unchanged.

Decomposition:
- Shared package sap2_kbd_pkg:
  - FSM state encoding typedef (kbd_state_t: IDLE=2'd0, PRESS_DB=2'd1, RELEASE_WAIT=2'd2, RELEASE_DB=2'd3).
  - Constant KBD_RESET_DATA=8'h00.
- One natural sub-module: kbd_debounce. It contains the counter plus the PRESS_DB/RELEASE_DB logic, outputs a one-cycle accept_pulse, and takes DEBOUNCE_CYCLES and CNT_W.
- The top level holds nibble assembly, ready/overrun and the handshake.

Test Plan:
1. CLR=1 two cycles, then strobe bounce 1,0,1,0 with DEBOUNCE_CYCLES=4 -> no acceptance; port_data=00, ready=0, nibble_pending=0.
2. Press key_code=A held 6 cycles, release 4 cycles, then press key_code=C held 4 cycles -> nibble_pending=1 after the first press; port_data=8'hAC and ready=1 exactly 4 cycles after C's strobe rises.
3. With ready=1, pulse acknowedge for 1 cycle -> ready=0 the next edge; port_data stays AC. A second acknowledge has no effect.
4. With ready=1 (port_data=AC), enter key 3 -> discarded; port_data=AC, nibble_pending=0. overrun=1 only if KBD_OVERRUN_EN is defined, otherwise 0.
5. Low nibble accepted on the same edge as an acknowledge of the previous byte -> ready falls and the key becomes the new high nibble (nibble_pending=1); overrun stays 0.
6. CLR=1 asserted mid-PRESS_DB with nibble_pending=1 and overrun=1 -> all outputs reset next edge. A following clean press of 5 becomes the high nibble.

Source files
------------

// File: rtl/sap2_kbd_pkg.sv
// ---------------------------------------------------------------------------
// sap2_kbd_pkg
// Shared definitions for the hex keyboard input-port controller.
//   kbd_state_t    : debounce FSM state encoding
//   KBD_RESET_DATA : value of the port-1 data lines after reset
// ---------------------------------------------------------------------------
package sap2_kbd_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_DB     = 2'd1,
        RELEASE_WAIT = 2'd2,
        RELEASE_DB   = 2'd3
    } kbd_state_t;

    localparam logic [7:0] KBD_RESET_DATA = 8'h00;

endpackage

// File: rtl/kbd_debounce.sv
// ---------------------------------------------------------------------------
// kbd_debounce
// Debounces the raw key_strobe from the hex encoder. A press is accepted
// once the strobe has been high for DEBOUNCE_CYCLES consecutive cycles; the
// key must then be seen low for DEBOUNCE_CYCLES consecutive cycles before
// another press can be recognised, so a held key gives one acceptance.
//
// Ports:
//   CLK          in   clock, posedge
//   CLR          in   synchronous reset, active-high
//   key_strobe   in   raw, bouncy key-down
//   accept_pulse out  one-cycle pulse; key_code must be sampled on the
//                     posedge that ends this cycle
//   state        out  current FSM state (debug visibility)
// ---------------------------------------------------------------------------
module kbd_debounce
    import sap2_kbd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       key_strobe,
    output logic       accept_pulse,
    output kbd_state_t state
);

    localparam logic [CNT_W-1:0] LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAXCNT = '1;
    // With a one-cycle debounce the first high (or low) sample is already
    // enough, so the *_DB states are skipped entirely.
    localparam bit SINGLE = (DEBOUNCE_CYCLES == 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;

    // Saturating increment: the counter never wraps back into the
    // debounce window.
    assign count_inc = (count == MAXCNT) ? count : count + ONE;

    // Acceptance is decoded from registered state so the top level can
    // capture key_code on the very edge that completes the debounce.
    always_comb begin
        accept_pulse = 1'b0;
        case (state)
            IDLE:     accept_pulse = key_strobe && SINGLE;
            PRESS_DB: accept_pulse = key_strobe && (count == LAST);
            default:  accept_pulse = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_strobe) begin
                        if (SINGLE) begin
                            state <= RELEASE_WAIT;
                            count <= '0;
                        end else begin
                            state <= PRESS_DB;
                            count <= ONE;
                        end
                    end
                end
                PRESS_DB: begin
                    if (!key_strobe) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (count == LAST) begin
                        state <= RELEASE_WAIT;
                    end else begin
                        count <= count_inc;
                    end
                end
                RELEASE_WAIT: begin
                    if (!key_strobe) begin
                        if (SINGLE) begin
                            state <= IDLE;
                            count <= '0;
                        end else begin
                            state <= RELEASE_DB;
                            count <= ONE;
                        end
                    end
                end
                RELEASE_DB: begin
                    if (key_strobe) begin
                        state <= RELEASE_WAIT;
                    end else if (count == LAST) begin
                        state <= IDLE;
                        count <= '0;
                    end else begin
                        count <= count_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/keyboard_port_controller.sv
// ---------------------------------------------------------------------------
// keyboard_port_controller
// Sequences the hex keyboard encoder feeding input port 1. Debounced
// keystrokes are assembled high nibble first into a byte, which is placed on
// port_data with ready raised (port 2 bit 0) until the CPU acknowledges it.
//
// Handshake: ready=1 means port_data holds an unread byte. The CPU reads it
// by raising acknowedge; ready drops on the next posedge and port_data keeps
// its value. acknowedge while ready=0 does nothing. Keystrokes accepted while
// an unread byte is waiting are thrown away. If an acknowledge and an
// acceptance share an edge, the acknowledge is applied first, so the new key
// is taken as the next high nibble.
//
// Build option: KBD_OVERRUN_EN -- when defined, a discarded keystroke sets the
// sticky overrun flag (cleared only by CLR); when undefined overrun is 0.
//
// Ports:
//   CLK            in   clock, posedge
//   CLR            in   synchronous reset, active-high
//   key_code[3:0]  in   hex value, valid while key_strobe is high
//   key_strobe     in   raw, bouncy key-down
//   acknowedge     in   CPU read strobe for port 1
//   port_data[7:0] out  assembled byte
//   ready          out  byte valid
//   nibble_pending out  high nibble captured, low nibble awaited
//   overrun        out  sticky keystroke-lost flag
//   dbg_state      out  debounce FSM state (debug visibility)
// ---------------------------------------------------------------------------
module keyboard_port_controller
    import sap2_kbd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [3:0] key_code,
    input  logic       key_strobe,
    input  logic       acknowedge,
    output logic [7:0] port_data,
    output logic       ready,
    output logic       nibble_pending,
    output logic       overrun,
    output kbd_state_t dbg_state
);

    logic       accept;
    logic       ack_hit;
    logic       busy;
    logic [3:0] hold_hi;

    kbd_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .CLK          (CLK),
        .CLR          (CLR),
        .key_strobe   (key_strobe),
        .accept_pulse (accept),
        .state        (dbg_state)
    );

    // Acknowledge takes effect before acceptance on the same edge, so the
    // "still full" decision uses ready as it will be after the acknowledge.
    assign ack_hit = acknowedge && ready;
    assign busy    = ready && !acknowedge;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            port_data      <= KBD_RESET_DATA;
            ready          <= 1'b0;
            nibble_pending <= 1'b0;
            hold_hi        <= 4'h0;
        end else begin
            if (ack_hit) begin
                ready <= 1'b0;
            end
            if (accept && !busy) begin
                if (!nibble_pending) begin
                    hold_hi        <= key_code;
                    nibble_pending <= 1'b1;
                end else begin
                    port_data      <= {hold_hi, key_code};
                    ready          <= 1'b1;
                    nibble_pending <= 1'b0;
                end
            end
        end
    end

`ifdef KBD_OVERRUN_EN
    always_ff @(posedge CLK) begin
        if (CLR) begin
            overrun <= 1'b0;
        end else if (accept && busy) begin
            overrun <= 1'b1;
        end
    end
`else
    assign overrun = 1'b0;
`endif

endmodule
